// File: rtl/switch_pre_cell_packer_pkg.sv
// Shared definitions for the switch core ingress path: FSM state encoding,
// descriptor field geometry and the cell-count ceiling.
package switch_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // Width of the last_bytes field: log2 of bytes per cell.
    function automatic int lb_width(input int cell_w);
        return $clog2(cell_w / 8);
    endfunction

    // Descriptor layout, LSB first: cell_cnt, portmap, last_bytes, trunc.
    function automatic int cnt_lsb();
        return 0;
    endfunction

    function automatic int port_lsb(input int cnt_w);
        return cnt_w;
    endfunction

    function automatic int lb_lsb(input int port_w, input int cnt_w);
        return cnt_w + port_w;
    endfunction

    function automatic int trunc_bit(input int cell_w, input int port_w, input int cnt_w);
        return cnt_w + port_w + lb_width(cell_w);
    endfunction

    function automatic int ptr_width(input int cell_w, input int port_w, input int cnt_w);
        return 1 + lb_width(cell_w) + port_w + cnt_w;
    endfunction

    // Largest cell count a frame may occupy before it is truncated.
    function automatic int max_cells(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/switch_pre_cell_packer_shifter.sv
// Beat-to-cell placement for the ingress packer. Beats land MSB-first; the
// working cell is cleared after each completed cell or flush, so a partial
// cell read out at flush time is already zero-padded in its LSBs.
module switch_cell_shifter #(
    parameter int DIN_W  = 8,
    parameter int CELL_W = 128,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [DIN_W-1:0]  din,
    output logic [CELL_W-1:0] beat_cell,
    output logic [CELL_W-1:0] part_cell,
    output logic              last_beat,
    output logic              empty,
    output logic [IDX_W-1:0]  idx
);

    localparam int BEATS = CELL_W / DIN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [CELL_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Working cell with the incoming beat dropped into its slot.
    always_comb begin
        beat_cell = buf_q;
        beat_cell[CELL_W - 1 - int'(idx_q) * DIN_W -: DIN_W] = din;
    end

    assign part_cell = buf_q;
    assign last_beat = (idx_q == LAST_IDX);
    assign empty     = (idx_q == '0);
    assign idx       = idx_q;

    // Advance the beat index, restarting on a completed cell or a flush.
    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        if (load) begin
            if (last_beat) begin
                buf_d = '0;
                idx_d = '0;
            end else begin
                buf_d = beat_cell;
                idx_d = idx_q + 1'b1;
            end
        end else if (flush) begin
            buf_d = '0;
            idx_d = '0;
        end
    end

    // Working cell and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/switch_pre_cell_packer.sv
// Ingress cell packer: packs a sof/dv/din beat stream into CELL_W-bit cells,
// writes one descriptor per accepted frame, truncates frames that exceed
// MAX_CELLS and drops frames that see backpressure at sof.
// Optional statistics counters are built when SWITCH_PRE_STATS_EN is defined.
module switch_pre_cell_packer
    import switch_core_pkg::*;
#(
    parameter int DIN_W  = 8,
    parameter int CELL_W = 128,
    parameter int PORT_W = 4,
    parameter int CNT_W  = 7,
    parameter int PTR_W  = ptr_width(CELL_W, PORT_W, CNT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic              dv,
    input  logic [DIN_W-1:0]  din,
    input  logic              i_cell_bp,
    output logic [CELL_W-1:0] i_cell_data_fifo_dout,
    output logic              i_cell_data_fifo_wr,
    output logic [PTR_W-1:0]  i_cell_ptr_fifo_dout,
    output logic              i_cell_ptr_fifo_wr,
    output logic              frame_drop
`ifdef SWITCH_PRE_STATS_EN
    ,
    output logic [15:0]       rx_frame_cnt,
    output logic [15:0]       drop_frame_cnt,
    output logic [15:0]       trunc_frame_cnt
`endif
);

    localparam int LB_W  = lb_width(CELL_W);
    localparam int BEATS = CELL_W / DIN_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BPB   = DIN_W / 8;
    localparam logic [CNT_W-1:0] MAX_CELLS = CNT_W'(max_cells(CNT_W));

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_base, cnt_sat;
    logic [PORT_W-1:0]   portmap_q, portmap_d;
    logic                trunc_q, trunc_d;
    logic [CELL_W-1:0]   data_q, data_d;
    logic                data_wr_q, data_wr_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                ptr_wr_q, ptr_wr_d;
    logic                drop_q, drop_d;

    logic                sh_load, sh_flush, sh_last, sh_empty;
    logic [CELL_W-1:0]   sh_beat_cell, sh_part_cell;
    logic [IDX_W-1:0]    sh_idx;
    logic [LB_W-1:0]     last_bytes;

    switch_cell_shifter #(
        .DIN_W  (DIN_W),
        .CELL_W (CELL_W),
        .IDX_W  (IDX_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .flush     (sh_flush),
        .din       (din),
        .beat_cell (sh_beat_cell),
        .part_cell (sh_part_cell),
        .last_beat (sh_last),
        .empty     (sh_empty),
        .idx       (sh_idx)
    );

    // A new frame counts from zero; the count never wraps.
    assign cnt_base   = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign cnt_sat    = (cnt_base == MAX_CELLS) ? cnt_base : cnt_base + 1'b1;
    // Beat index times bytes per beat is already below bytes per cell.
    assign last_bytes = LB_W'(int'(sh_idx) * BPB);

    // Frame FSM: next state, cell/descriptor writes and drop pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        portmap_d = portmap_q;
        trunc_d   = trunc_q;
        data_d    = data_q;
        data_wr_d = 1'b0;
        ptr_d     = ptr_q;
        ptr_wr_d  = 1'b0;
        drop_d    = 1'b0;
        sh_load   = 1'b0;
        sh_flush  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sof && dv) begin
                    cnt_d   = '0;
                    trunc_d = 1'b0;
                    if (i_cell_bp) begin
                        state_d = ST_DROP;
                        drop_d  = 1'b1;
                    end else begin
                        state_d   = ST_FILL;
                        portmap_d = din[PORT_W-1:0];
                        sh_load   = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (dv) begin
                    if (cnt_q == MAX_CELLS && sh_empty) begin
                        state_d = ST_DROP;
                        trunc_d = 1'b1;
                    end else begin
                        sh_load = 1'b1;
                    end
                end else begin
                    state_d  = ST_IDLE;
                    sh_flush = 1'b1;
                    if (!sh_empty) begin
                        data_d    = sh_part_cell;
                        data_wr_d = 1'b1;
                        cnt_d     = cnt_sat;
                    end
                    ptr_wr_d = 1'b1;
                    ptr_d    = {1'b0, last_bytes, portmap_q, cnt_d};
                end
            end
            ST_DROP: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    trunc_d = 1'b0;
                    if (trunc_q) begin
                        ptr_wr_d = 1'b1;
                        ptr_d    = {1'b1, {LB_W{1'b0}}, portmap_q, MAX_CELLS};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (sh_load && sh_last) begin
            data_d    = sh_beat_cell;
            data_wr_d = 1'b1;
            cnt_d     = cnt_sat;
        end
    end

    // FSM, frame context and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            portmap_q <= '0;
            trunc_q   <= 1'b0;
            data_q    <= '0;
            data_wr_q <= 1'b0;
            ptr_q     <= '0;
            ptr_wr_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            portmap_q <= portmap_d;
            trunc_q   <= trunc_d;
            data_q    <= data_d;
            data_wr_q <= data_wr_d;
            ptr_q     <= ptr_d;
            ptr_wr_q  <= ptr_wr_d;
            drop_q    <= drop_d;
        end
    end

    assign i_cell_data_fifo_dout = data_q;
    assign i_cell_data_fifo_wr   = data_wr_q;
    assign i_cell_ptr_fifo_dout  = ptr_q;
    assign i_cell_ptr_fifo_wr    = ptr_wr_q;
    assign frame_drop            = drop_q;

`ifdef SWITCH_PRE_STATS_EN
    logic [15:0] rx_frame_cnt_q, rx_frame_cnt_d;
    logic [15:0] drop_frame_cnt_q, drop_frame_cnt_d;
    logic [15:0] trunc_frame_cnt_q, trunc_frame_cnt_d;

    // Saturating frame statistics.
    always_comb begin
        rx_frame_cnt_d    = rx_frame_cnt_q;
        drop_frame_cnt_d  = drop_frame_cnt_q;
        trunc_frame_cnt_d = trunc_frame_cnt_q;
        if (ptr_wr_d && rx_frame_cnt_q != '1)
            rx_frame_cnt_d = rx_frame_cnt_q + 16'd1;
        if (drop_d && drop_frame_cnt_q != '1)
            drop_frame_cnt_d = drop_frame_cnt_q + 16'd1;
        if (ptr_wr_d && state_q == ST_DROP && trunc_frame_cnt_q != '1)
            trunc_frame_cnt_d = trunc_frame_cnt_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_frame_cnt_q    <= '0;
            drop_frame_cnt_q  <= '0;
            trunc_frame_cnt_q <= '0;
        end else begin
            rx_frame_cnt_q    <= rx_frame_cnt_d;
            drop_frame_cnt_q  <= drop_frame_cnt_d;
            trunc_frame_cnt_q <= trunc_frame_cnt_d;
        end
    end

    assign rx_frame_cnt    = rx_frame_cnt_q;
    assign drop_frame_cnt  = drop_frame_cnt_q;
    assign trunc_frame_cnt = trunc_frame_cnt_q;
`endif

endmodule

// File: doc/switch_pre_cell_packer.md
Name: switch_pre_cell_packer

Overview:
- Parametrised ingress cell packer for the switch core.
- Accepts a beat stream (sof/dv/din) from the ingress MAC path and packs it MSB-first into CELL_W-bit cells for the cell data FIFO.
- At end of frame, writes one descriptor to the cell pointer FIFO.
- Adds support for frames that are not a whole number of cells, a length-limit truncation mode, and drop-on-backpressure.

Parameters:
- DIN_W, 8, beat width in bits; must be 8, 16 or 32 and divide CELL_W.
- CELL_W, 128, cell width in bits.
- PORT_W, 4, width of the destination port map, taken from the LSBs of the first beat.
- CNT_W, 7, width of the cell counter; MAX_CELLS = 2^CNT_W-1.
- PTR_W, 1+log2(CELL_W/8)+PORT_W+CNT_W (16 at defaults), descriptor width; derived, do not override.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- sof  in  1  start of frame; qualifies the first beat, only meaningful with dv=1
- dv  in  1  beat valid; frame ends on the first cycle with dv=0
- din  in  DIN_W  beat data
- i_cell_bp  in  1  backpressure from the data/pointer FIFOs; sampled only at sof
- i_cell_data_fifo_dout  out  CELL_W  packed cell
- i_cell_data_fifo_wr  out  1  one-cycle write strobe
- i_cell_ptr_fifo_dout  out  PTR_W  descriptor {trunc, last_bytes, portmap, cell_cnt}
- i_cell_ptr_fifo_wr  out  1  one-cycle write strobe
- frame_drop  out  1  one-cycle pulse when a frame is dropped due to backpressure

Behaviour:
- Reset:
  - Synchronous, active-high; all outputs are 0 on the cycle after rst is sampled high.
  - State returns to IDLE; any partial cell and counters are discarded; no descriptor is emitted.
- States: IDLE, FILL, DROP.
- IDLE:
  - sof=1, dv=1, i_cell_bp=0: capture beat 0 into the top DIN_W bits of the cell, latch portmap=din[PORT_W-1:0], set beat index=1, go to FILL.
  - sof=1, dv=1, i_cell_bp=1: go to DROP and pulse frame_drop the next cycle.
  - sof without dv is ignored.
- FILL, dv=1:
  - Beat k of a cell lands at bits [CELL_W-1-k*DIN_W -: DIN_W].
  - When the beat completes a cell, i_cell_data_fifo_wr pulses the next cycle and cell_cnt increments.
  - sof asserted during FILL is treated as plain data.
- FILL, dv=0 (end of frame). On the next cycle:
  - If the cell is partial, the unfilled LSBs are zero-padded and written (cell_cnt increments).
  - The descriptor is written in the same cycle: last_bytes = valid bytes in the final cell mod CELL_W/8 (0 means full); trunc=0.
  - Go to IDLE. A new sof on that following cycle is accepted, so the minimum inter-frame gap is one dv=0 cycle.
- Truncation:
  - If a beat arrives with cell_cnt==MAX_CELLS and the current cell empty, go to DROP with trunc latched.
  - At dv=0, write the descriptor with trunc=1, cell_cnt=MAX_CELLS, last_bytes=0.
- DROP:
  - Consume beats with no data writes.
  - At dv=0, write the descriptor only if trunc is latched; a backpressure drop writes nothing.
  - Return to IDLE.
- i_cell_bp is ignored mid-frame. The FIFOs are sized so that an accepted frame always fits.
- cell_cnt saturates and never wraps; the beat index wraps modulo CELL_W/DIN_W.

Optional Feature:
- Macro: SWITCH_PRE_STATS_EN.
- When defined, the block adds 16-bit saturating output counters:
  - rx_frame_cnt: frames with a descriptor written
  - drop_frame_cnt: frames dropped on backpressure
  - trunc_frame_cnt: truncated frames
  - All three are cleared by rst.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package switch_core_pkg holds:
  - state encodings
  - descriptor field offsets and widths (LB_W=log2(CELL_W/8), PORT_W, CNT_W)
  - MAX_CELLS
- Sub-module switch_cell_shifter: beat-to-cell placement, zero-pad on flush, beat index, full flag.
- The top level holds the FSM, counters and descriptor.

Test Plan:
- 32-byte frame 0x01..0x20 (bp=0): two cell writes, 0x0102..10 then 0x1112..20. Descriptor {0,0,portmap=1,cnt=2} one cycle after dv falls.
- 20-byte frame: two writes; second cell = bytes 17..20 followed by 12 zero bytes. Descriptor last_bytes=4, cnt=2.
- sof with i_cell_bp=1 on a 64-byte frame: no writes, one frame_drop pulse. Next frame after a one-cycle gap is packed normally.
- 2048-byte frame: 127 cell writes, then silence. Descriptor trunc=1, cnt=127, written at end of dv.
- Back-to-back 16-byte frames with a single dv=0 gap: both descriptors written; the second sof is accepted on the descriptor cycle.
- rst pulsed at beat 9 of a frame: no writes or descriptor. Subsequent dv-only beats are ignored until the next sof.
